// File: rtl/green_filter_axil_regs.sv
// AXI4-Lite register block for the green-channel pixel filter: CTRL, PIXEL_IN,
// a registered filtered PIXEL_OUT and a PIXEL_CNT of pixels pushed while enabled.
module green_filter_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready
);

  localparam logic [1:0] SEL_CTRL = 2'd0, SEL_PIN = 2'd1, SEL_POUT = 2'd2, SEL_CNT = 2'd3;

  logic        aw_lat, w_lat;
  logic [1:0]  aw_sel;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        en;
  logic [23:0] pix_in;
  logic [31:0] pix_out, pix_cnt;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic aw_lat_n, w_lat_n, bvalid_n, rvalid_n;
  logic [31:0] rd_mux;

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

  assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
  assign w_hs   = s00_axi_wvalid & s00_axi_wready;
  assign b_hs   = s00_axi_bvalid & s00_axi_bready;
  assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
  assign r_hs   = s00_axi_rvalid & s00_axi_rready;
  // Commit exactly once: bvalid rises on the commit edge and blocks a repeat.
  assign commit = aw_lat & w_lat & ~s00_axi_bvalid;

  assign aw_lat_n = b_hs ? 1'b0 : (aw_lat | aw_hs);
  assign w_lat_n  = b_hs ? 1'b0 : (w_lat | w_hs);
  assign bvalid_n = commit ? 1'b1 : (b_hs ? 1'b0 : s00_axi_bvalid);
  assign rvalid_n = ar_hs ? 1'b1 : (r_hs ? 1'b0 : s00_axi_rvalid);

  always_comb begin
    rd_mux = 32'h0;
    case (s00_axi_araddr[3:2])
      SEL_CTRL: rd_mux = {31'h0, en};
      SEL_PIN:  rd_mux = {8'h00, pix_in};
      SEL_POUT: rd_mux = pix_out;
      default:  rd_mux = pix_cnt;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_bresp   <= 2'b00;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= 32'h0;
      s00_axi_rresp   <= 2'b00;
      aw_lat  <= 1'b0;
      w_lat   <= 1'b0;
      aw_sel  <= 2'd0;
      w_data  <= 32'h0;
      w_strb  <= 4'h0;
      en      <= 1'b0;
      pix_in  <= 24'h0;
      pix_out <= 32'h0;
      pix_cnt <= 32'h0;
    end else begin
      aw_lat          <= aw_lat_n;
      w_lat           <= w_lat_n;
      s00_axi_bvalid  <= bvalid_n;
      s00_axi_rvalid  <= rvalid_n;
      s00_axi_awready <= ~aw_lat_n & ~bvalid_n;
      s00_axi_wready  <= ~w_lat_n & ~bvalid_n;
      s00_axi_arready <= ~rvalid_n;
      if (aw_hs) aw_sel <= s00_axi_awaddr[3:2];
      if (w_hs) begin
        w_data <= s00_axi_wdata[31:0];
        w_strb <= s00_axi_wstrb[3:0];
      end
      if (commit) begin
        s00_axi_bresp <= (aw_sel == SEL_POUT) ? 2'b10 : 2'b00;
        case (aw_sel)
          SEL_CTRL: if (w_strb[0]) en <= w_data[0];
          SEL_PIN: begin
            for (int b = 0; b < 3; b++)
              if (w_strb[b]) pix_in[b*8 +: 8] <= w_data[b*8 +: 8];
            if (en) pix_cnt <= pix_cnt + 32'd1;
          end
          SEL_CNT: pix_cnt <= 32'h0;
          default: ;
        endcase
      end
      if (ar_hs) begin
        s00_axi_rdata <= rd_mux;
        s00_axi_rresp <= 2'b00;
      end
      pix_out <= en ? {16'h0000, pix_in[15:8], 8'h00} : {8'h00, pix_in};
    end
  end

endmodule
